usb_line_state_ctrl: RTL and testbench
======================================

Name: usb_line_state_ctrl

Overview:
Parametrised successor to the SIE's combinational J/K polarity encoder. Still provides registered J/K encodings for the transmit path. Adds a receive-side line monitor that synchronises and filters the D+/D- pair, classifies the line state, and runs a bus-condition FSM (connect, idle, active, bus reset, resume, disconnect). Sits between the USB PHY pins and the SIE.

Parameters:
SYNC_STAGES, 2, synchroniser flop count on usbWireIn (>=2)
FS_FILTER, 1, consecutive stable cycles before a synchronised value is accepted, full-speed
LS_FILTER, 4, same as FS_FILTER, low-speed
CNT_W, 8, width of the hold and filter counters
CONNECT_TICKS, 16, J cycles needed in DISC to declare a connect
IDLE_TICKS, 8, J cycles needed in ACTIVE to declare idle
RESET_TICKS, 32, SE0 cycles needed to declare a bus reset
RESUME_TICKS, 24, K cycles needed to declare a resume
DISC_TICKS, 64, SE0 cycles needed in RESET to declare a disconnect (must be > RESET_TICKS)

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous, active-low reset
fullSpeedPolarity  in  1  1 = FS polarity (J=D+ high), 0 = LS polarity
fullSpeedBitRate  in  1  1 = use FS_FILTER, 0 = use LS_FILTER
usbWireIn  in  2  [1]=D+, [0]=D- raw from PHY
JBit  out  2  registered J encoding {D+,D-}
KBit  out  2  registered K encoding {D+,D-}
lineState  out  2  filtered state: 00 SE0, 01 J, 10 K, 11 SE1
busState  out  3  FSM state: 000 DISC, 001 IDLE, 010 ACTIVE, 011 RESET, 100 RESUME
busReset  out  1  high while busState==RESET
resumePulse  out  1  one-cycle pulse on entry to RESUME

Behaviour:
- Reset values: JBit=01, KBit=10, lineState=00, busState=DISC, busReset=0, resumePulse=0, all counters 0, synchroniser flops 00.
- J/K encoding: registered with 1-cycle latency. Polarity 1 -> JBit=10, KBit=01. Polarity 0 -> JBit=01, KBit=10.
- Classification: D+D- = 00 -> SE0, 11 -> SE1. A value equal to the current registered JBit -> J; equal to KBit -> K.
- Synchroniser: SYNC_STAGES flops.
- Filter: the filter counter clears when the synchroniser output changes and increments otherwise. lineState takes the synchronised value once it has been equal for F consecutive cycles, where F is FS_FILTER or LS_FILTER per fullSpeedBitRate. Latency from a pin change to lineState = SYNC_STAGES+F cycles (3 with FS defaults). Any change inside the filter window restarts the count.
- Hold counter: clears to 0 on the cycle lineState changes, increments every cycle, saturates at 2^CNT_W-1. "Held N" means the counter equals N-1; the transition takes effect on that clock edge.
- FSM transitions:
  - DISC: J held CONNECT_TICKS -> IDLE. Other states are ignored.
  - IDLE: lineState != J -> ACTIVE on the next edge.
  - ACTIVE: J held IDLE_TICKS -> IDLE; SE0 held RESET_TICKS -> RESET; K held RESUME_TICKS -> RESUME.
  - RESET: lineState J -> IDLE; SE0 held DISC_TICKS -> DISC. The hold count continues from RESET entry and does not restart.
  - RESUME: SE0 -> ACTIVE; J -> IDLE.
  - SE1 in any state: no transition, and the hold counter keeps counting SE1.
- Polarity change: a detected change of the registered fullSpeedPolarity clears the hold counter and forces DISC on the same edge. This takes priority over all other transitions.
- A bit-rate change updates F only. An in-progress filter count is compared against the new F.
- Reset mid-operation returns all state to the reset values immediately (asynchronously).

Optional Feature:
LINE_EVENT_IRQ_EN
- Defined: adds port eventFlags out 4 and port eventClr in 4.
  - eventFlags bits are sticky: [0] connect (DISC->IDLE), [1] bus reset entry, [2] resume entry, [3] disconnect (RESET->DISC).
  - eventClr is write-1-to-clear. If set and clear coincide on a bit, set wins.
  - eventFlags reset to 0.
- Undefined: neither port exists and there is no flag logic. All other behaviour is identical.

Test Plan:
1. Reset release, fullSpeedPolarity=1 -> after 1 cycle JBit=10, KBit=01. Toggle to 0 -> JBit=01, KBit=10 one cycle later, and busState forced to 000.
2. FS, usbWireIn=10 held 40 cycles from DISC -> lineState=01 after 3 cycles; busState=001 exactly 16 cycles after lineState becomes J.
3. IDLE, drive SE0 for 40 cycles -> busState 010 then 011 after 32 SE0 cycles, busReset=1. Return to J -> busState=001 and busReset=0.
4. ACTIVE, drive K for 24 cycles -> busState=100 and resumePulse high exactly 1 cycle. Then SE0 -> busState=010.
5. LS mode (fullSpeedBitRate=0), 3-cycle glitch to 00 on an idle J line -> lineState stays 01. A 6-cycle SE0 -> lineState=00.
6. RESET, SE0 held 70 cycles -> busState=000 at hold count 63. With LINE_EVENT_IRQ_EN, eventFlags[3]=1; eventClr=1000 clears it, and a simultaneous set keeps it at 1.

Source files
------------

// File: rtl/usb_line_state_ctrl_if.sv
// usb_line_state_ctrl_if
// Groups the PHY-side and SIE-side signals of usb_line_state_ctrl.
//   slave  : view used by usb_line_state_ctrl
//   master : view used by the SIE / testbench
// Signals:
//   fullSpeedPolarity  1 = FS polarity (J = D+ high), 0 = LS polarity
//   fullSpeedBitRate   1 = full-speed filter length, 0 = low-speed
//   usbWireIn[1:0]     raw {D+, D-} from the PHY
//   JBit, KBit         registered J/K encodings {D+, D-}
//   lineState          filtered line state (00 SE0, 01 J, 10 K, 11 SE1)
//   busState           bus condition (000 DISC .. 100 RESUME)
//   busReset           high while in bus reset
//   resumePulse        one-cycle pulse on resume entry
//   eventFlags/eventClr sticky event flags, write-1-to-clear
//                      (only when LINE_EVENT_IRQ_EN is defined)
interface usb_line_state_ctrl_if;
    logic       fullSpeedPolarity;
    logic       fullSpeedBitRate;
    logic [1:0] usbWireIn;
    logic [1:0] JBit;
    logic [1:0] KBit;
    logic [1:0] lineState;
    logic [2:0] busState;
    logic       busReset;
    logic       resumePulse;
`ifdef LINE_EVENT_IRQ_EN
    logic [3:0] eventFlags;
    logic [3:0] eventClr;

    modport slave (
        input  fullSpeedPolarity, fullSpeedBitRate, usbWireIn, eventClr,
        output JBit, KBit, lineState, busState, busReset, resumePulse, eventFlags
    );
    modport master (
        output fullSpeedPolarity, fullSpeedBitRate, usbWireIn, eventClr,
        input  JBit, KBit, lineState, busState, busReset, resumePulse, eventFlags
    );
`else
    modport slave (
        input  fullSpeedPolarity, fullSpeedBitRate, usbWireIn,
        output JBit, KBit, lineState, busState, busReset, resumePulse
    );
    modport master (
        output fullSpeedPolarity, fullSpeedBitRate, usbWireIn,
        input  JBit, KBit, lineState, busState, busReset, resumePulse
    );
`endif
endinterface

// File: rtl/usb_line_state_ctrl.sv
// usb_line_state_ctrl
// Registered J/K polarity encoder plus a receive-side line monitor:
// synchroniser -> stability filter -> line-state classifier -> hold
// counter -> bus-condition FSM.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    usb_line_state_ctrl_if.slave (see interface header)
// Optional feature macro: LINE_EVENT_IRQ_EN adds sticky eventFlags with
// write-1-to-clear eventClr (set wins over clear).
//
// state  | meaning
// DISC   | no device / waiting for J held CONNECT_TICKS
// IDLE   | J on the bus
// ACTIVE | bus traffic (non-J seen)
// RESET  | SE0 held RESET_TICKS, busReset asserted
// RESUME | K held RESUME_TICKS
module usb_line_state_ctrl #(
    parameter int SYNC_STAGES   = 2,
    parameter int FS_FILTER     = 1,
    parameter int LS_FILTER     = 4,
    parameter int CNT_W         = 8,
    parameter int CONNECT_TICKS = 16,
    parameter int IDLE_TICKS    = 8,
    parameter int RESET_TICKS   = 32,
    parameter int RESUME_TICKS  = 24,
    parameter int DISC_TICKS    = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    usb_line_state_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_DISC   = 3'b000,
        ST_IDLE   = 3'b001,
        ST_ACTIVE = 3'b010,
        ST_RESET  = 3'b011,
        ST_RESUME = 3'b100
    } bus_state_t;

    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] HOLD_CONN   = CNT_W'(CONNECT_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_IDLE   = CNT_W'(IDLE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_RESET  = CNT_W'(RESET_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_RESUME = CNT_W'(RESUME_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_DISC   = CNT_W'(DISC_TICKS - 1);

    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       sync_out;
    logic [1:0]       sync_prev;
    logic             sync_chg;
    logic [CNT_W-1:0] flt_cnt;
    logic [CNT_W-1:0] filt_len;
    logic [CNT_W:0]   run_len;
    logic             accept;
    logic [1:0]       j_q;
    logic [1:0]       k_q;
    logic             pol_chg;
    logic [1:0]       line_cls;
    logic [1:0]       line_q;
    logic [1:0]       line_nxt;
    logic [CNT_W-1:0] hold_cnt;
    bus_state_t       state;
    bus_state_t       state_nxt;
    logic             bus_reset_q;
    logic             resume_q;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign sync_chg = (sync_out != sync_prev);
    assign filt_len = bus.fullSpeedBitRate ? CNT_W'(FS_FILTER) : CNT_W'(LS_FILTER);

    // run_len: stable cycles of sync_out before the current one, so the
    // current cycle is the (run_len+1)-th equal cycle.
    assign run_len = sync_chg ? '0 : ({1'b0, flt_cnt} + 1'b1);
    assign accept  = (run_len + 1'b1) >= {1'b0, filt_len};

    // Compared against the registered polarity so J/K and the FSM flush
    // move together on the same edge.
    assign pol_chg = (bus.fullSpeedPolarity != j_q[1]);

    always_comb begin
        line_cls = LS_K;
        if (sync_out == 2'b00)      line_cls = LS_SE0;
        else if (sync_out == 2'b11) line_cls = LS_SE1;
        else if (sync_out == j_q)   line_cls = LS_J;
    end

    assign line_nxt = accept ? line_cls : line_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
            sync_prev <= 2'b00;
            flt_cnt   <= '0;
            j_q       <= 2'b01;
            k_q       <= 2'b10;
            line_q    <= LS_SE0;
            hold_cnt  <= '0;
        end else begin
            sync_q[0] <= bus.usbWireIn;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sync_prev <= sync_out;
            if (sync_chg)              flt_cnt <= '0;
            else if (flt_cnt != CNT_MAX) flt_cnt <= flt_cnt + 1'b1;
            j_q    <= bus.fullSpeedPolarity ? 2'b10 : 2'b01;
            k_q    <= bus.fullSpeedPolarity ? 2'b01 : 2'b10;
            line_q <= line_nxt;
            if (pol_chg || (line_nxt != line_q)) hold_cnt <= '0;
            else if (hold_cnt != CNT_MAX)        hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // SE1 never matches any transition, so it simply holds the state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_DISC: begin
                if (line_q == LS_J && hold_cnt == HOLD_CONN) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (line_q == LS_SE0 || line_q == LS_K) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (line_q == LS_J && hold_cnt == HOLD_IDLE)        state_nxt = ST_IDLE;
                else if (line_q == LS_SE0 && hold_cnt == HOLD_RESET) state_nxt = ST_RESET;
                else if (line_q == LS_K && hold_cnt == HOLD_RESUME)  state_nxt = ST_RESUME;
            end
            ST_RESET: begin
                // hold_cnt keeps counting the same SE0 run from before entry
                if (line_q == LS_J)                                 state_nxt = ST_IDLE;
                else if (line_q == LS_SE0 && hold_cnt == HOLD_DISC) state_nxt = ST_DISC;
            end
            ST_RESUME: begin
                if (line_q == LS_SE0)    state_nxt = ST_ACTIVE;
                else if (line_q == LS_J) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_DISC;
        endcase
        if (pol_chg) state_nxt = ST_DISC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_DISC;
            bus_reset_q <= 1'b0;
            resume_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus_reset_q <= (state_nxt == ST_RESET);
            resume_q    <= (state_nxt == ST_RESUME) && (state != ST_RESUME);
        end
    end

`ifdef LINE_EVENT_IRQ_EN
    logic [3:0] evt_q;
    logic [3:0] evt_set;

    assign evt_set = {(state == ST_RESET) && (state_nxt == ST_DISC),
                      (state != ST_RESUME) && (state_nxt == ST_RESUME),
                      (state != ST_RESET) && (state_nxt == ST_RESET),
                      (state == ST_DISC) && (state_nxt == ST_IDLE)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) evt_q <= 4'b0000;
        else        evt_q <= (evt_q & ~bus.eventClr) | evt_set;
    end

    assign bus.eventFlags = evt_q;
`endif

    assign bus.JBit        = j_q;
    assign bus.KBit        = k_q;
    assign bus.lineState   = line_q;
    assign bus.busState    = state;
    assign bus.busReset    = bus_reset_q;
    assign bus.resumePulse = resume_q;

endmodule

// File: tb/tb_usb_line_state_ctrl.sv
// Scoreboard bench for usb_line_state_ctrl: stimulus pushes expected values
// tagged with the clock cycle they must appear on; a monitor at each falling
// edge pops every entry due in that cycle and compares it.
module tb_usb_line_state_ctrl;

    localparam int ID_J    = 0;
    localparam int ID_K    = 1;
    localparam int ID_LINE = 2;
    localparam int ID_BUS  = 3;
    localparam int ID_BRST = 4;
    localparam int ID_RES  = 5;
    localparam int ID_EVT  = 6;

    typedef struct {
        int         cyc;
        int         id;
        logic [3:0] val;
        string      name;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    usb_line_state_ctrl_if ifc ();

    usb_line_state_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] actual(input int id);
        logic [3:0] r;
        r = 4'hx;
        case (id)
            ID_J:    r = {2'b00, ifc.JBit};
            ID_K:    r = {2'b00, ifc.KBit};
            ID_LINE: r = {2'b00, ifc.lineState};
            ID_BUS:  r = {1'b0, ifc.busState};
            ID_BRST: r = {3'b000, ifc.busReset};
            ID_RES:  r = {3'b000, ifc.resumePulse};
`ifdef LINE_EVENT_IRQ_EN
            ID_EVT:  r = ifc.eventFlags;
`endif
            default: r = 4'hx;
        endcase
        return r;
    endfunction

    task automatic sb_push(input int ofs, input int id, input logic [3:0] val, input string name);
        exp_t e;
        e.cyc  = cyc + ofs;
        e.id   = id;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [3:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                act = actual(sb[i].id);
                checks = checks + 1;
                if (sb[i].cyc < cyc || act !== sb[i].val) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", sb[i].name, sb[i].cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ifc.fullSpeedPolarity = 1'b1;
        ifc.fullSpeedBitRate  = 1'b1;
        ifc.usbWireIn         = 2'b00;
`ifdef LINE_EVENT_IRQ_EN
        ifc.eventClr = 4'b0000;
`endif
        step(3);

        // reset values, then first edge after release with FS polarity
        sb_push(0, ID_J,    4'd1, "rst_jbit");
        sb_push(0, ID_K,    4'd2, "rst_kbit");
        sb_push(0, ID_LINE, 4'd0, "rst_line");
        sb_push(0, ID_BUS,  4'd0, "rst_bus");
        sb_push(0, ID_BRST, 4'd0, "rst_busreset");
        sb_push(0, ID_RES,  4'd0, "rst_resume");
`ifdef LINE_EVENT_IRQ_EN
        sb_push(0, ID_EVT,  4'd0, "rst_evt");
`endif
        sb_push(1, ID_J,    4'd2, "pol1_jbit");
        sb_push(1, ID_K,    4'd1, "pol1_kbit");
        sb_push(1, ID_BUS,  4'd0, "pol1_bus");
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1);

        // polarity toggle 1 -> 0 -> 1
        step(1);
        ifc.fullSpeedPolarity = 1'b0;
        sb_push(1, ID_J, 4'd1, "pol0_jbit");
        sb_push(1, ID_K, 4'd2, "pol0_kbit");
        step(1);
        ifc.fullSpeedPolarity = 1'b1;
        sb_push(1, ID_J, 4'd2, "pol1b_jbit");
        sb_push(1, ID_K, 4'd1, "pol1b_kbit");
        step(2);

        // connect: J from DISC
        ifc.usbWireIn = 2'b10;
        sb_push(2,  ID_LINE, 4'd0, "conn_line_pre");
        sb_push(3,  ID_LINE, 4'd1, "conn_line_j");
        sb_push(18, ID_BUS,  4'd0, "conn_bus_pre");
        sb_push(19, ID_BUS,  4'd1, "conn_bus_idle");
        step(40);

        // SE0 from IDLE -> ACTIVE -> RESET, then J -> IDLE
        ifc.usbWireIn = 2'b00;
        sb_push(2,  ID_LINE, 4'd1, "se0_line_pre");
        sb_push(3,  ID_LINE, 4'd0, "se0_line");
        sb_push(3,  ID_BUS,  4'd1, "se0_bus_idle");
        sb_push(4,  ID_BUS,  4'd2, "se0_bus_active");
        sb_push(34, ID_BUS,  4'd2, "se0_bus_prereset");
        sb_push(34, ID_BRST, 4'd0, "se0_busreset_pre");
        sb_push(35, ID_BUS,  4'd3, "se0_bus_reset");
        sb_push(35, ID_BRST, 4'd1, "se0_busreset");
        step(40);
        ifc.usbWireIn = 2'b10;
        sb_push(3, ID_BUS,  4'd3, "rstj_bus_pre");
        sb_push(3, ID_BRST, 4'd1, "rstj_busreset_pre");
        sb_push(4, ID_BUS,  4'd1, "rstj_bus_idle");
        sb_push(4, ID_BRST, 4'd0, "rstj_busreset_off");
        step(10);

        // K from IDLE -> ACTIVE -> RESUME, SE0 -> ACTIVE, J -> IDLE
        ifc.usbWireIn = 2'b01;
        sb_push(3,  ID_LINE, 4'd2, "k_line");
        sb_push(4,  ID_BUS,  4'd2, "k_bus_active");
        sb_push(26, ID_BUS,  4'd2, "k_bus_pre");
        sb_push(26, ID_RES,  4'd0, "k_pulse_pre");
        sb_push(27, ID_BUS,  4'd4, "k_bus_resume");
        sb_push(27, ID_RES,  4'd1, "k_pulse");
        sb_push(28, ID_BUS,  4'd4, "k_bus_stay");
        sb_push(28, ID_RES,  4'd0, "k_pulse_end");
        step(30);
        ifc.usbWireIn = 2'b00;
        sb_push(3, ID_BUS, 4'd4, "res_se0_pre");
        sb_push(4, ID_BUS, 4'd2, "res_se0_active");
        step(10);
        ifc.usbWireIn = 2'b10;
        sb_push(10, ID_BUS, 4'd2, "act_j_pre");
        sb_push(11, ID_BUS, 4'd1, "act_j_idle");
        step(20);

        // low-speed filter: 3-cycle glitch rejected
        ifc.fullSpeedBitRate = 1'b0;
        ifc.usbWireIn = 2'b00;
        for (int i = 3; i <= 7; i++) sb_push(i, ID_LINE, 4'd1, "ls_glitch_line");
        sb_push(7, ID_BUS, 4'd1, "ls_glitch_bus");
        step(3);
        ifc.usbWireIn = 2'b10;
        step(10);

        // low-speed filter: 6-cycle SE0 accepted
        ifc.usbWireIn = 2'b00;
        sb_push(5,  ID_LINE, 4'd1, "ls_se0_pre");
        sb_push(6,  ID_LINE, 4'd0, "ls_se0_line");
        sb_push(6,  ID_BUS,  4'd1, "ls_se0_bus_pre");
        sb_push(7,  ID_BUS,  4'd2, "ls_se0_bus_active");
        sb_push(11, ID_LINE, 4'd0, "ls_j_pre");
        sb_push(12, ID_LINE, 4'd1, "ls_j_line");
        sb_push(19, ID_BUS,  4'd2, "ls_j_bus_pre");
        sb_push(20, ID_BUS,  4'd1, "ls_j_bus_idle");
        step(6);
        ifc.usbWireIn = 2'b10;
        step(24);

        // long SE0: RESET then disconnect at hold count 63
        ifc.fullSpeedBitRate = 1'b1;
        ifc.usbWireIn = 2'b00;
        sb_push(4,  ID_BUS,  4'd2, "disc_bus_active");
        sb_push(35, ID_BUS,  4'd3, "disc_bus_reset");
        sb_push(66, ID_BUS,  4'd3, "disc_bus_pre");
        sb_push(66, ID_BRST, 4'd1, "disc_busreset_pre");
        sb_push(67, ID_BUS,  4'd0, "disc_bus_disc");
        sb_push(67, ID_BRST, 4'd0, "disc_busreset_off");
`ifdef LINE_EVENT_IRQ_EN
        sb_push(66, ID_EVT, 4'b0111, "evt_pre_disc");
        sb_push(67, ID_EVT, 4'b1111, "evt_disc");
`endif
        step(70);

        // clear flags, then reconnect with a clear colliding with the set
`ifdef LINE_EVENT_IRQ_EN
        ifc.eventClr = 4'b1001;
        sb_push(0, ID_EVT, 4'b1111, "evt_before_clr");
        sb_push(1, ID_EVT, 4'b0110, "evt_clr");
`endif
        step(1);
`ifdef LINE_EVENT_IRQ_EN
        ifc.eventClr = 4'b0000;
`endif
        ifc.usbWireIn = 2'b10;
        sb_push(3,  ID_LINE, 4'd1, "reconn_line");
        sb_push(18, ID_BUS,  4'd0, "reconn_bus_pre");
        sb_push(19, ID_BUS,  4'd1, "reconn_bus_idle");
        step(18);
`ifdef LINE_EVENT_IRQ_EN
        ifc.eventClr = 4'b0001;
        sb_push(0, ID_EVT, 4'b0110, "evt_pre_setclr");
        sb_push(1, ID_EVT, 4'b0111, "evt_set_wins");
`endif
        step(1);
`ifdef LINE_EVENT_IRQ_EN
        ifc.eventClr = 4'b0000;
        sb_push(1, ID_EVT, 4'b0111, "evt_sticky");
`endif
        step(5);

        // polarity change while IDLE forces DISC; J pins now read as K
        ifc.fullSpeedPolarity = 1'b0;
        sb_push(1,  ID_BUS,  4'd0, "polchg_bus_disc");
        sb_push(1,  ID_J,    4'd1, "polchg_jbit");
        sb_push(1,  ID_LINE, 4'd1, "polchg_line_pre");
        sb_push(2,  ID_LINE, 4'd2, "polchg_line_k");
        sb_push(20, ID_BUS,  4'd0, "polchg_bus_stay");
        step(25);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
